sram_rgb_segment_writer: RTL and testbench



---
 rtl/sram_rgb_segment_writer.sv | 235 +++++++++++++++++++++++
 tb/tb_sram_rgb_segment_writer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rgb_segment_writer.sv
// Packs 24-bit RGB pixels in groups of 4 into six SRAM words (Red/Green pairs, Blue even/odd).
// Optional macro SEG_WRITER_DOUBLE_BUFFER_EN adds a second pixel buffer so collection overlaps writes.
module sram_rgb_segment_writer #(
  parameter int unsigned NUM_PIXELS     = 76800,
  parameter logic [17:0] RED_BASE       = 18'd146944,
  parameter logic [17:0] GREEN_BASE     = 18'd185344,
  parameter logic [17:0] BLUE_EVEN_BASE = 18'd223744,
  parameter logic [17:0] BLUE_ODD_BASE  = 18'd242944
) (
  input  logic        Clock_50,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Pixel_valid,
  output logic        Pixel_ready,
  input  logic [7:0]  Pixel_R,
  input  logic [7:0]  Pixel_G,
  input  logic [7:0]  Pixel_B,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done
);
  localparam logic [15:0] LAST_GROUP = 16'(NUM_PIXELS / 4 - 1);

  // Each write state names the word loaded on its exit edge; S_WR_END holds Blue odd on the bus.
  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WR_RED_1, S_WR_GREEN_0,
    S_WR_GREEN_1, S_WR_BLUE_E, S_WR_BLUE_O, S_WR_END
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_we_n, w_we_n_next;
  logic [17:0] r_addr, w_addr_next;
  logic [15:0] r_data, w_data_next;
  logic        r_ready, w_ready_next;
  logic        r_busy, w_busy_next;
  logic        r_done, w_done_next;
  logic [1:0]  r_slot, w_slot_next;
  logic [15:0] r_g, w_g_next;

  logic [7:0]  r_pix_r [2][4];
  logic [7:0]  r_pix_g [2][4];
  logic [7:0]  r_pix_b [2][4];

  logic        w_accept, w_fill_done, w_last, w_alt_ready;
  logic        w_fill_sel, w_wr_sel, w_rd_sel;
  logic [15:0] w_rd_g;
  logic [17:0] w_g1, w_g2;

`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
  localparam logic [15:0] NUM_GROUPS = 16'(NUM_PIXELS / 4);
  logic        r_fill_sel, w_fill_sel_next;
  logic        r_wr_sel, w_wr_sel_next;
  logic [1:0]  r_full, w_full_next;
  logic [15:0] r_acc, w_acc_next;

  assign w_fill_sel  = r_fill_sel;
  assign w_wr_sel    = r_wr_sel;
  // The alternate buffer may complete on the same edge the current write sequence ends.
  assign w_alt_ready = r_full[~r_wr_sel] | (w_fill_done & (r_fill_sel != r_wr_sel));
  assign w_rd_sel    = (r_state == S_WR_END) ? ~r_wr_sel : r_wr_sel;
`else
  assign w_fill_sel  = 1'b0;
  assign w_wr_sel    = 1'b0;
  assign w_alt_ready = 1'b0;
  assign w_rd_sel    = 1'b0;
`endif

  assign w_accept    = Pixel_valid & r_ready;
  assign w_fill_done = w_accept & (r_slot == 2'd3);
  assign w_last      = (r_g == LAST_GROUP);
  assign w_rd_g      = (r_state == S_WR_END) ? (r_g + 16'd1) : r_g;
  assign w_g1        = {2'b00, w_rd_g};
  assign w_g2        = {1'b0, w_rd_g, 1'b0};

  always_ff @(posedge Clock_50) begin
    if (w_accept) begin
      r_pix_r[w_fill_sel][r_slot] <= Pixel_R;
      r_pix_g[w_fill_sel][r_slot] <= Pixel_G;
      r_pix_b[w_fill_sel][r_slot] <= Pixel_B;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_we_n  <= 1'b1;
      r_addr  <= 18'd0;
      r_data  <= 16'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_slot  <= 2'd0;
      r_g     <= 16'd0;
`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
      r_fill_sel <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_full     <= 2'b00;
      r_acc      <= 16'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_we_n  <= w_we_n_next;
      r_addr  <= w_addr_next;
      r_data  <= w_data_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_slot  <= w_slot_next;
      r_g     <= w_g_next;
`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
      r_fill_sel <= w_fill_sel_next;
      r_wr_sel   <= w_wr_sel_next;
      r_full     <= w_full_next;
      r_acc      <= w_acc_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (Start) w_state_next = S_COLLECT;
      S_COLLECT:    if (w_fill_done) w_state_next = S_WR_RED_1;
      S_WR_RED_1:   w_state_next = S_WR_GREEN_0;
      S_WR_GREEN_0: w_state_next = S_WR_GREEN_1;
      S_WR_GREEN_1: w_state_next = S_WR_BLUE_E;
      S_WR_BLUE_E:  w_state_next = S_WR_BLUE_O;
      S_WR_BLUE_O:  w_state_next = S_WR_END;
      S_WR_END: begin
        if (w_last)           w_state_next = S_IDLE;
        else if (w_alt_ready) w_state_next = S_WR_RED_1;
        else                  w_state_next = S_COLLECT;
      end
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_we_n_next  = 1'b1;
    w_addr_next  = r_addr;
    w_data_next  = r_data;
    w_ready_next = r_ready;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_slot_next  = w_accept ? (r_slot + 2'd1) : r_slot;
    w_g_next     = r_g;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_busy_next  = 1'b1;
          w_ready_next = 1'b1;
          w_slot_next  = 2'd0;
          w_g_next     = 16'd0;
        end
      end
      S_COLLECT: begin
        if (w_fill_done) begin
          w_we_n_next  = 1'b0;
          w_ready_next = 1'b0;
          w_addr_next  = RED_BASE + w_g2;
          w_data_next  = {r_pix_r[w_rd_sel][0], r_pix_r[w_rd_sel][1]};
        end
      end
      S_WR_RED_1: begin
        w_we_n_next = 1'b0;
        w_addr_next = RED_BASE + w_g2 + 18'd1;
        w_data_next = {r_pix_r[w_rd_sel][2], r_pix_r[w_rd_sel][3]};
      end
      S_WR_GREEN_0: begin
        w_we_n_next = 1'b0;
        w_addr_next = GREEN_BASE + w_g2;
        w_data_next = {r_pix_g[w_rd_sel][0], r_pix_g[w_rd_sel][1]};
      end
      S_WR_GREEN_1: begin
        w_we_n_next = 1'b0;
        w_addr_next = GREEN_BASE + w_g2 + 18'd1;
        w_data_next = {r_pix_g[w_rd_sel][2], r_pix_g[w_rd_sel][3]};
      end
      S_WR_BLUE_E: begin
        w_we_n_next = 1'b0;
        w_addr_next = BLUE_EVEN_BASE + w_g1;
        w_data_next = {r_pix_b[w_rd_sel][0], r_pix_b[w_rd_sel][2]};
      end
      S_WR_BLUE_O: begin
        w_we_n_next = 1'b0;
        w_addr_next = BLUE_ODD_BASE + w_g1;
        w_data_next = {r_pix_b[w_rd_sel][1], r_pix_b[w_rd_sel][3]};
      end
      S_WR_END: begin
        if (w_last) begin
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_ready_next = 1'b0;
          w_g_next     = 16'd0;
        end else begin
          w_g_next     = r_g + 16'd1;
          w_ready_next = 1'b1;
          if (w_alt_ready) begin
            w_we_n_next = 1'b0;
            w_addr_next = RED_BASE + w_g2;
            w_data_next = {r_pix_r[w_rd_sel][0], r_pix_r[w_rd_sel][1]};
          end
        end
      end
      default: ;
    endcase

`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
    w_fill_sel_next = w_fill_done ? ~r_fill_sel : r_fill_sel;
    w_wr_sel_next   = (r_state == S_WR_END && !w_last) ? ~r_wr_sel : r_wr_sel;
    w_full_next     = r_full;
    if (r_state == S_WR_END) w_full_next[r_wr_sel] = 1'b0;
    if (w_fill_done)         w_full_next[r_fill_sel] = 1'b1;
    w_acc_next = r_acc + {15'd0, w_fill_done};
    if (r_state == S_IDLE) begin
      w_fill_sel_next = 1'b0;
      w_wr_sel_next   = 1'b0;
      w_full_next     = 2'b00;
      w_acc_next      = 16'd0;
    end
    // Keep accepting until both buffers hold data or the whole frame has been taken in.
    w_ready_next = w_busy_next & ~(&w_full_next) & (w_acc_next != NUM_GROUPS);
`endif
  end

  assign Pixel_ready     = r_ready;
  assign SRAM_address    = r_addr;
  assign SRAM_write_data = r_data;
  assign SRAM_we_n       = r_we_n;
  assign Busy            = r_busy;
  assign Done            = r_done;

endmodule

// File: tb/tb_sram_rgb_segment_writer.sv
// Directed bench for sram_rgb_segment_writer with an 8-pixel frame (two groups).
module tb_sram_rgb_segment_writer;
  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Pixel_valid = 1'b0;
  logic [7:0]  Pixel_R = 8'h00, Pixel_G = 8'h00, Pixel_B = 8'h00;
  logic        Pixel_ready, SRAM_we_n, Busy, Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;

  int checks = 0;
  int errors = 0;
  int frame_wb = 0;

`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
  localparam int EXP_RDY_LOW = 0;
`else
  localparam int EXP_RDY_LOW = 6;
`endif

  localparam logic [7:0] PIX_R [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h40, 8'h41, 8'h42, 8'h43};
  localparam logic [7:0] PIX_G [8] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h50, 8'h51, 8'h52, 8'h53};
  localparam logic [7:0] PIX_B [8] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h60, 8'h61, 8'h62, 8'h63};
  localparam logic [17:0] ADDR_G0 [6] = '{18'd146944, 18'd146945, 18'd185344, 18'd185345, 18'd223744, 18'd242944};
  localparam logic [17:0] ADDR_G1 [6] = '{18'd146946, 18'd146947, 18'd185346, 18'd185347, 18'd223745, 18'd242945};
  localparam logic [15:0] DATA_A [6] = '{16'h1011, 16'h1213, 16'h2021, 16'h2223, 16'h3032, 16'h3133};
  localparam logic [15:0] DATA_B [6] = '{16'h4041, 16'h4243, 16'h5051, 16'h5253, 16'h6062, 16'h6163};

  sram_rgb_segment_writer #(.NUM_PIXELS(8)) dut (
    .Clock_50       (clk),
    .Reset          (Reset),
    .Start          (Start),
    .Pixel_valid    (Pixel_valid),
    .Pixel_ready    (Pixel_ready),
    .Pixel_R        (Pixel_R),
    .Pixel_G        (Pixel_G),
    .Pixel_B        (Pixel_B),
    .SRAM_address   (SRAM_address),
    .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n      (SRAM_we_n),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #10 clk = ~clk;

  // Negedge observer: records every presented write word, write-burst lengths and Done pulses.
  int cyc = 0, we_cnt = 0, done_cnt = 0, rdy_low = 0, run = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [17:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int run_len [$];

  always @(negedge clk) begin
    cyc++;
    if (SRAM_we_n === 1'b0) begin
      wr_addr.push_back(SRAM_address);
      wr_data.push_back(SRAM_write_data);
      we_cnt++;
      run++;
      last_wr_cyc = cyc;
    end else if (run > 0) begin
      run_len.push_back(run);
      run = 0;
    end
    if (Done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (Busy === 1'b1 && Pixel_ready === 1'b0) rdy_low++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int count, input int gap);
    for (int i = first; i < first + count; i++) begin
      int n;
      n = 0;
      Pixel_R = PIX_R[i];
      Pixel_G = PIX_G[i];
      Pixel_B = PIX_B[i];
      Pixel_valid = 1'b1;
      while (Pixel_ready !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      checks++;
      if (Pixel_ready !== 1'b1) begin
        errors++;
        $display("FAIL pixel_accept[%0d]: ready=%b after %0d cycles, required 1", i, Pixel_ready, n);
      end
      tick();
      if (gap > 0) begin
        Pixel_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    Pixel_valid = 1'b0;
  endtask

  task automatic wait_writes(input int base, input int n);
    int k = 0;
    while (we_cnt - base < n && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (we_cnt - base < n) begin
      errors++;
      $display("FAIL write_timeout: got %0d writes, required %0d", we_cnt - base, n);
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (Pixel_ready !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    checks++;
    if (Pixel_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: ready=%b, required 1", Pixel_ready);
    end
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout: no Done pulse seen");
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) tick();
    checks++; if (SRAM_we_n !== 1'b1)          begin errors++; $display("FAIL rst_we_n: got %b required 1", SRAM_we_n); end
    checks++; if (SRAM_address !== 18'd0)      begin errors++; $display("FAIL rst_addr: got %0d required 0", SRAM_address); end
    checks++; if (SRAM_write_data !== 16'd0)   begin errors++; $display("FAIL rst_data: got %h required 0000", SRAM_write_data); end
    checks++; if (Pixel_ready !== 1'b0)        begin errors++; $display("FAIL rst_ready: got %b required 0", Pixel_ready); end
    checks++; if (Busy !== 1'b0)               begin errors++; $display("FAIL rst_busy: got %b required 0", Busy); end
    checks++; if (Done !== 1'b0)               begin errors++; $display("FAIL rst_done: got %b required 0", Done); end
    Reset = 1'b0;
    tick();
    checks++; if (Pixel_ready !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: ready=%b busy=%b required 0/0", Pixel_ready, Busy); end
  endtask

  task automatic test_first_group();
    int wb, rl;
    frame_wb = we_cnt;
    pulse_start();
    checks++; if (Busy !== 1'b1)        begin errors++; $display("FAIL busy_after_start: got %b required 1", Busy); end
    checks++; if (Pixel_ready !== 1'b1) begin errors++; $display("FAIL ready_after_start: got %b required 1", Pixel_ready); end
    wb = we_cnt;
    rl = rdy_low;
    send_pixels(0, 4, 0);
    wait_writes(wb, 6);
    wait_ready();
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (wr_addr[wb+k] !== ADDR_G0[k]) begin errors++; $display("FAIL g0_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ADDR_G0[k]); end
      checks++; if (wr_data[wb+k] !== DATA_A[k])  begin errors++; $display("FAIL g0_data[%0d]: got %h required %h", k, wr_data[wb+k], DATA_A[k]); end
    end
    checks++; if (we_cnt - wb != 6)               begin errors++; $display("FAIL g0_we_cycles: got %0d required 6", we_cnt - wb); end
    checks++; if (rdy_low - rl != EXP_RDY_LOW)    begin errors++; $display("FAIL g0_ready_low: got %0d required %0d", rdy_low - rl, EXP_RDY_LOW); end
    checks++; if (done_cnt != 0)                  begin errors++; $display("FAIL g0_no_done: got %0d pulses required 0", done_cnt); end
    checks++; if (Busy !== 1'b1)                  begin errors++; $display("FAIL g0_busy: got %b required 1", Busy); end
  endtask

  task automatic test_second_group();
    int wb, d0;
    wb = we_cnt;
    d0 = done_cnt;
    send_pixels(4, 4, 0);
    wait_done(d0);
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (wr_addr[wb+k] !== ADDR_G1[k]) begin errors++; $display("FAIL g1_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ADDR_G1[k]); end
      checks++; if (wr_data[wb+k] !== DATA_B[k])  begin errors++; $display("FAIL g1_data[%0d]: got %h required %h", k, wr_data[wb+k], DATA_B[k]); end
    end
    checks++; if (done_cnt - d0 != 1)             begin errors++; $display("FAIL frame_done_count: got %0d required 1", done_cnt - d0); end
    checks++; if (done_cyc != last_wr_cyc + 1)    begin errors++; $display("FAIL done_timing: done at %0d required %0d", done_cyc, last_wr_cyc + 1); end
    checks++; if (Busy !== 1'b0)                  begin errors++; $display("FAIL frame_busy: got %b required 0", Busy); end
    checks++; if (Pixel_ready !== 1'b0)           begin errors++; $display("FAIL frame_ready: got %b required 0", Pixel_ready); end
    checks++; if (SRAM_we_n !== 1'b1)             begin errors++; $display("FAIL frame_we_n: got %b required 1", SRAM_we_n); end
    checks++; if (we_cnt - frame_wb != 12)        begin errors++; $display("FAIL frame_writes: got %0d required 12", we_cnt - frame_wb); end
  endtask

  task automatic test_toggle_valid();
    int fb, wb, rl, d0;
    fb = we_cnt;
    d0 = done_cnt;
    pulse_start();
    wb = we_cnt;
    rl = rdy_low;
    send_pixels(0, 4, 1);
    wait_writes(wb, 6);
    wait_ready();
    for (int k = 0; k < 6; k++) begin
      checks++; if (wr_addr[wb+k] !== ADDR_G0[k]) begin errors++; $display("FAIL tog_g0_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ADDR_G0[k]); end
      checks++; if (wr_data[wb+k] !== DATA_A[k])  begin errors++; $display("FAIL tog_g0_data[%0d]: got %h required %h", k, wr_data[wb+k], DATA_A[k]); end
    end
    checks++; if (rdy_low - rl != EXP_RDY_LOW)    begin errors++; $display("FAIL tog_ready_low: got %0d required %0d", rdy_low - rl, EXP_RDY_LOW); end
    pulse_start();
    checks++; if (Busy !== 1'b1)                  begin errors++; $display("FAIL midframe_start_busy: got %b required 1", Busy); end
    wb = we_cnt;
    send_pixels(4, 4, 1);
    wait_done(d0);
    repeat (2) tick();
    for (int k = 0; k < 6; k++) begin
      checks++; if (wr_addr[wb+k] !== ADDR_G1[k]) begin errors++; $display("FAIL tog_g1_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ADDR_G1[k]); end
      checks++; if (wr_data[wb+k] !== DATA_B[k])  begin errors++; $display("FAIL tog_g1_data[%0d]: got %h required %h", k, wr_data[wb+k], DATA_B[k]); end
    end
    checks++; if (we_cnt - fb != 12)              begin errors++; $display("FAIL tog_frame_writes: got %0d required 12", we_cnt - fb); end
    checks++; if (done_cnt - d0 != 1)             begin errors++; $display("FAIL tog_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_abort();
    int wb;
    pulse_start();
    wb = we_cnt;
    send_pixels(0, 2, 0);
    Pixel_R = PIX_R[2];
    Pixel_G = PIX_G[2];
    Pixel_B = PIX_B[2];
    Pixel_valid = 1'b1;
    Reset = 1'b1;
    tick();
    checks++; if (SRAM_we_n !== 1'b1)          begin errors++; $display("FAIL abort_we_n: got %b required 1", SRAM_we_n); end
    checks++; if (SRAM_address !== 18'd0)      begin errors++; $display("FAIL abort_addr: got %0d required 0", SRAM_address); end
    checks++; if (SRAM_write_data !== 16'd0)   begin errors++; $display("FAIL abort_data: got %h required 0000", SRAM_write_data); end
    checks++; if (Pixel_ready !== 1'b0)        begin errors++; $display("FAIL abort_ready: got %b required 0", Pixel_ready); end
    checks++; if (Busy !== 1'b0)               begin errors++; $display("FAIL abort_busy: got %b required 0", Busy); end
    checks++; if (Done !== 1'b0)               begin errors++; $display("FAIL abort_done: got %b required 0", Done); end
    Reset = 1'b0;
    repeat (8) tick();
    checks++; if (we_cnt != wb)                begin errors++; $display("FAIL abort_no_writes: got %0d writes required 0", we_cnt - wb); end
    checks++; if (Pixel_ready !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL abort_idle: ready=%b busy=%b required 0/0", Pixel_ready, Busy); end
    Pixel_valid = 1'b0;
    pulse_start();
    wb = we_cnt;
    send_pixels(4, 4, 0);
    wait_writes(wb, 6);
    for (int k = 0; k < 6; k++) begin
      checks++; if (wr_addr[wb+k] !== ADDR_G0[k]) begin errors++; $display("FAIL restart_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ADDR_G0[k]); end
      checks++; if (wr_data[wb+k] !== DATA_B[k])  begin errors++; $display("FAIL restart_data[%0d]: got %h required %h", k, wr_data[wb+k], DATA_B[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int wb, rb, d0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    rb = run_len.size();
    wb = we_cnt;
    d0 = done_cnt;
    pulse_start();
    send_pixels(0, 8, 0);
    wait_done(d0);
    repeat (2) tick();
    for (int k = 0; k < 12; k++) begin
      logic [17:0] ea;
      logic [15:0] ed;
      ea = (k < 6) ? ADDR_G0[k] : ADDR_G1[k-6];
      ed = (k < 6) ? DATA_A[k] : DATA_B[k-6];
      checks++; if (wr_addr[wb+k] !== ea) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d required %0d", k, wr_addr[wb+k], ea); end
      checks++; if (wr_data[wb+k] !== ed) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", k, wr_data[wb+k], ed); end
    end
`ifdef SEG_WRITER_DOUBLE_BUFFER_EN
    checks++; if (run_len.size() - rb != 1) begin errors++; $display("FAIL b2b_bursts: got %0d required 1", run_len.size() - rb); end
    checks++; if (run_len[rb] != 12)        begin errors++; $display("FAIL b2b_burst_len: got %0d required 12", run_len[rb]); end
`else
    checks++; if (run_len.size() - rb != 2) begin errors++; $display("FAIL b2b_bursts: got %0d required 2", run_len.size() - rb); end
    checks++; if (run_len[rb] != 6)         begin errors++; $display("FAIL b2b_burst0_len: got %0d required 6", run_len[rb]); end
    checks++; if (run_len[rb+1] != 6)       begin errors++; $display("FAIL b2b_burst1_len: got %0d required 6", run_len[rb+1]); end
`endif
    checks++; if (done_cnt - d0 != 1)       begin errors++; $display("FAIL b2b_done_count: got %0d required 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_first_group();
    test_second_group();
    test_toggle_valid();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
